// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared encodings for the pipeline hazard controller: FSM
//               states, hazard priority ordering and the bubble-insert level.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MDU_WAIT = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_REDIRECT = 2'b11
  } state_t;

  // Hazard kinds listed from highest to lowest priority
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_DMEM     = 3'd1,
    HZ_MDU      = 3'd2,
    HZ_BRANCH   = 3'd3,
    HZ_LOAD_USE = 3'd4,
    HZ_IMEM     = 3'd5
  } hazard_t;

  // Level on a *_flush line that loads a NOP bubble into the stage register
  localparam logic INSERT_BUBBLE = 1'b1;

  // Pick the single highest-priority active hazard
  function automatic hazard_t top_hazard(input logic dmem, input logic mdu,
                                         input logic branch, input logic ld_use,
                                         input logic imem);
    hazard_t hz;
    hz = HZ_NONE;
    if (dmem)        hz = HZ_DMEM;
    else if (mdu)    hz = HZ_MDU;
    else if (branch) hz = HZ_BRANCH;
    else if (ld_use) hz = HZ_LOAD_USE;
    else if (imem)   hz = HZ_IMEM;
    return hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at the maximum value once reached
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush sequencer for the 5-stage pipeline. Merges branch
//               mispredict, load-use, MUL/DIV occupancy and memory wait
//               states into one set of PC / stage-register controls per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mispredict,
  input  logic             load_use,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mdu_timeout
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MDU_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  hazard_t         hz;
  logic            run_like;
  logic [WD_W-1:0] wd_count;

  assign state_o = state;

  // State register; reset abandons any wait and returns to RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; MEM_WAIT released and REDIRECT reuse RUN decode
  always_comb begin
    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    next_state   = state;
    run_like     = 1'b0;
    // EX and ID already hold bubbles in REDIRECT, so branch and load-use are moot
    hz = top_hazard(dmem_busy, mdu_start & ~mdu_done,
                    mispredict & (state != ST_REDIRECT),
                    load_use & (state != ST_REDIRECT), imem_busy);

    if (!reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush  = INSERT_BUBBLE;
      id_ex_flush  = INSERT_BUBBLE;
      ex_mem_flush = INSERT_BUBBLE;
      next_state   = ST_RUN;
    end else begin
      case (state)
        ST_MDU_WAIT: begin
          if (dmem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          end else if (!mdu_done) begin
            {pc_en, if_id_en, id_ex_en} = '0;
            ex_mem_flush = INSERT_BUBBLE;
          end else begin
            next_state = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          end else begin
            run_like = 1'b1;
          end
        end
        default: run_like = 1'b1;
      endcase

      if (run_like) begin
        next_state = ST_RUN;
        case (hz)
          HZ_DMEM: begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            next_state = ST_MEM_WAIT;
          end
          HZ_MDU: begin
            {pc_en, if_id_en, id_ex_en} = '0;
            ex_mem_flush = INSERT_BUBBLE;
            next_state   = ST_MDU_WAIT;
          end
          HZ_BRANCH: begin
            pc_redirect = 1'b1;
            if_id_flush = INSERT_BUBBLE;
            id_ex_flush = INSERT_BUBBLE;
            next_state  = ST_REDIRECT;
          end
          HZ_LOAD_USE: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = INSERT_BUBBLE;
          end
          HZ_IMEM: begin
            pc_en       = 1'b0;
            if_id_flush = INSERT_BUBBLE;
          end
          default: ;
        endcase
      end
    end
  end

  // MDU watchdog: restarts on entry to MDU_WAIT, counts undone cycles, sticky flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_count    <= '0;
      mdu_timeout <= 1'b0;
    end else if ((state != ST_MDU_WAIT) && (next_state == ST_MDU_WAIT)) begin
      wd_count <= '0;
    end else if ((state == ST_MDU_WAIT) && !mdu_done && (wd_count != WD_MAX)) begin
      wd_count <= wd_count + 1'b1;
      if (wd_count == WD_LAST) begin
        mdu_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_redirect),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Self-checking bench: directed vector table, hand-written
//               watchdog / saturation sequences and randomized stimulus
//               against a behavioural model. Two instances (16-bit and
//               4-bit counters) share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int T_WD   = 64;
  localparam int MAX16  = 65535;
  localparam int MAX4   = 15;

  // Control vector: {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //                  if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [8:0] C_RST = 9'b000000111;
  localparam logic [8:0] C_DEF = 9'b101111000;
  localparam logic [8:0] C_FRZ = 9'b000000000;
  localparam logic [8:0] C_MDU = 9'b000011001;
  localparam logic [8:0] C_BR  = 9'b111111110;
  localparam logic [8:0] C_LU  = 9'b000111010;
  localparam logic [8:0] C_IM  = 9'b001111100;

  logic clk = 1'b0;
  logic reset, mispredict, load_use, mdu_start, mdu_done, imem_busy, dmem_busy;

  logic pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mdu_timeout;
  logic [1:0]  state_o;
  logic [15:0] stall_cycles, flush_count;

  logic pc_en4, pc_redirect4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic if_id_flush4, id_ex_flush4, ex_mem_flush4, mdu_timeout4;
  logic [1:0] state_o4;
  logic [3:0] stall_cycles4, flush_count4;

  logic [8:0] dut_ctl, dut_ctl4;
  assign dut_ctl  = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush};
  assign dut_ctl4 = {pc_en4, pc_redirect4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4,
                     if_id_flush4, id_ex_flush4, ex_mem_flush4};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(16), .MDU_TIMEOUT(T_WD)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict), .load_use(load_use),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_en(pc_en), .pc_redirect(pc_redirect),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .state_o(state_o), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .mdu_timeout(mdu_timeout)
  );

  pipeline_hazard_controller #(.CNT_W(4), .MDU_TIMEOUT(T_WD)) dut4 (
    .clk(clk), .reset(reset), .mispredict(mispredict), .load_use(load_use),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_en(pc_en4), .pc_redirect(pc_redirect4),
    .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4),
    .mem_wb_en(mem_wb_en4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .ex_mem_flush(ex_mem_flush4), .state_o(state_o4), .stall_cycles(stall_cycles4),
    .flush_count(flush_count4), .mdu_timeout(mdu_timeout4)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: mode 0=RUN 1=MDU_WAIT 2=MEM_WAIT 3=REDIRECT
  int m_state, m_stall, m_flush, m_stall4, m_flush4, m_wd;
  bit m_to;

  typedef struct {
    logic [6:0] in;   // {reset, mispredict, load_use, mdu_start, mdu_done, imem_busy, dmem_busy}
    logic [8:0] ctl;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Behavioural rules: which hazard wins this cycle and where the FSM goes next
  function automatic void model_comb(input int st, input logic [6:0] in,
                                     output logic [8:0] ctl, output int nxt);
    logic rst_n, mp, lu, ms, md, ib, db;
    logic pe, pr, ie, de, xe, we, fi, fd, fx;
    bit in_redirect;
    {rst_n, mp, lu, ms, md, ib, db} = in;
    {pe, pr, ie, de, xe, we, fi, fd, fx} = C_DEF;
    nxt = 0;
    in_redirect = (st == 3);
    if (!rst_n) begin
      {pe, pr, ie, de, xe, we, fi, fd, fx} = C_RST;
    end else if (st == 1) begin
      if (db)       begin {pe, ie, de, xe, we} = 5'b0; nxt = 1; end
      else if (!md) begin {pe, ie, de} = 3'b0; fx = 1'b1; nxt = 1; end
    end else if (st == 2 && db) begin
      {pe, ie, de, xe, we} = 5'b0; nxt = 2;
    end else begin
      if (db)                      begin {pe, ie, de, xe, we} = 5'b0; nxt = 2; end
      else if (ms && !md)          begin {pe, ie, de} = 3'b0; fx = 1'b1; nxt = 1; end
      else if (mp && !in_redirect) begin pr = 1'b1; fi = 1'b1; fd = 1'b1; nxt = 3; end
      else if (lu && !in_redirect) begin pe = 1'b0; ie = 1'b0; fd = 1'b1; end
      else if (ib)                 begin pe = 1'b0; fi = 1'b1; end
    end
    ctl = {pe, pr, ie, de, xe, we, fi, fd, fx};
  endfunction

  // One clock: drive, check at negedge, advance the model after the edge
  task automatic run_cycle(input logic [6:0] in, input bit has_exp,
                           input logic [8:0] exp_ctl, input logic [1:0] exp_st);
    logic [8:0] mctl;
    int nxt;
    {reset, mispredict, load_use, mdu_start, mdu_done, imem_busy, dmem_busy} = in;
    @(negedge clk);
    model_comb(m_state, in, mctl, nxt);
    if (has_exp) begin
      check("tbl_ctl", 32'(dut_ctl), 32'(exp_ctl));
      check("tbl_state", 32'(state_o), 32'(exp_st));
    end
    check("ctl", 32'(dut_ctl), 32'(mctl));
    check("state", 32'(state_o), 32'(m_state));
    check("ctl_w4", 32'(dut_ctl4), 32'(mctl));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("flush_count", 32'(flush_count), 32'(m_flush));
    check("stall_cycles_w4", 32'(stall_cycles4), 32'(m_stall4));
    check("flush_count_w4", 32'(flush_count4), 32'(m_flush4));
    check("mdu_timeout", 32'(mdu_timeout), 32'(m_to));
    @(posedge clk);
    #1;
    if (!in[6]) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0; m_wd = 0; m_to = 0;
    end else begin
      if (mctl[7])  begin m_flush = sat_inc(m_flush, MAX16); m_flush4 = sat_inc(m_flush4, MAX4); end
      if (!mctl[8]) begin m_stall = sat_inc(m_stall, MAX16); m_stall4 = sat_inc(m_stall4, MAX4); end
      if (m_state != 1 && nxt == 1) m_wd = 0;
      else if (m_state == 1 && !in[2]) begin
        if (m_wd < T_WD) m_wd++;
        if (m_wd == T_WD) m_to = 1;
      end
      m_state = nxt;
    end
  endtask

  initial begin
    {reset, mispredict, load_use, mdu_start, mdu_done, imem_busy, dmem_busy} = 7'b0;
    @(posedge clk);
    #1;
    m_state = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0; m_wd = 0; m_to = 0;

    // Directed vectors (expected values derived by hand)
    tbl.push_back('{7'b0100001, C_RST, 2'd0});
    tbl.push_back('{7'b0100001, C_RST, 2'd0});
    tbl.push_back('{7'b0100001, C_RST, 2'd0});
    tbl.push_back('{7'b1000000, C_DEF, 2'd0});
    tbl.push_back('{7'b1100000, C_BR,  2'd0});
    tbl.push_back('{7'b1100000, C_DEF, 2'd3});
    tbl.push_back('{7'b1000000, C_DEF, 2'd0});
    tbl.push_back('{7'b1001000, C_MDU, 2'd0});
    tbl.push_back('{7'b1000000, C_MDU, 2'd1});
    tbl.push_back('{7'b1000000, C_MDU, 2'd1});
    tbl.push_back('{7'b1000000, C_MDU, 2'd1});
    tbl.push_back('{7'b1000100, C_DEF, 2'd1});
    tbl.push_back('{7'b1000000, C_DEF, 2'd0});   // 12: stall_cycles = 4
    tbl.push_back('{7'b0000000, C_RST, 2'd0});
    tbl.push_back('{7'b1100001, C_FRZ, 2'd0});
    tbl.push_back('{7'b1100001, C_FRZ, 2'd2});
    tbl.push_back('{7'b1100001, C_FRZ, 2'd2});
    tbl.push_back('{7'b1100000, C_BR,  2'd2});
    tbl.push_back('{7'b1100000, C_DEF, 2'd3});   // 18: flush 1, stall 3
    tbl.push_back('{7'b1010000, C_LU,  2'd0});
    tbl.push_back('{7'b1000010, C_IM,  2'd0});
    tbl.push_back('{7'b1010010, C_LU,  2'd0});
    tbl.push_back('{7'b1001100, C_DEF, 2'd0});
    tbl.push_back('{7'b1101000, C_MDU, 2'd0});
    tbl.push_back('{7'b1000001, C_FRZ, 2'd1});
    tbl.push_back('{7'b1000100, C_DEF, 2'd1});
    tbl.push_back('{7'b1110000, C_BR,  2'd0});
    tbl.push_back('{7'b1010010, C_IM,  2'd3});
    tbl.push_back('{7'b1000001, C_FRZ, 2'd0});
    tbl.push_back('{7'b0000001, C_RST, 2'd2});
    tbl.push_back('{7'b1000000, C_DEF, 2'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].in, 1'b1, tbl[i].ctl, tbl[i].st);
      if (i == 11) check("mdu_stall_total", 32'(stall_cycles), 32'd4);
      if (i == 17) begin
        check("memwait_flush_total", 32'(flush_count), 32'd1);
        check("memwait_stall_total", 32'(stall_cycles), 32'd3);
      end
    end

    // Watchdog: MDU op that never completes
    run_cycle(7'b0000000, 1'b0, C_DEF, 2'd0);
    run_cycle(7'b1001000, 1'b0, C_DEF, 2'd0);
    for (int j = 1; j <= 70; j++) begin
      run_cycle(7'b1000000, 1'b0, C_DEF, 2'd0);
      check("wd_timeout", 32'(mdu_timeout), (j >= T_WD) ? 32'd1 : 32'd0);
    end
    run_cycle(7'b1000100, 1'b0, C_DEF, 2'd0);
    for (int j = 0; j < 3; j++) run_cycle(7'b1000000, 1'b0, C_DEF, 2'd0);
    check("wd_sticky", 32'(mdu_timeout), 32'd1);
    check("wd_state_run", 32'(state_o), 32'd0);
    run_cycle(7'b0000000, 1'b0, C_DEF, 2'd0);
    check("wd_cleared_by_reset", 32'(mdu_timeout), 32'd0);

    // Saturation: 4-bit stall counter under a long load-use
    for (int k = 1; k <= 20; k++) begin
      run_cycle(7'b1010000, 1'b0, C_DEF, 2'd0);
      check("sat_stall_w4", 32'(stall_cycles4), (k < 15) ? 32'(k) : 32'd15);
      check("sat_stall_w16", 32'(stall_cycles), 32'(k));
      check("lu_id_ex_flush", 32'(id_ex_flush4), 32'd1);
    end

    // Randomized stimulus against the model
    for (int r = 0; r < 600; r++) begin
      logic [6:0] in;
      in[6] = ($urandom_range(0, 39) != 0);
      in[5] = ($urandom_range(0, 3) == 0);
      in[4] = ($urandom_range(0, 3) == 0);
      in[3] = ($urandom_range(0, 4) == 0);
      in[2] = ($urandom_range(0, 2) == 0);
      in[1] = ($urandom_range(0, 3) == 0);
      in[0] = ($urandom_range(0, 4) == 0);
      run_cycle(in, 1'b0, C_DEF, 2'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
